// File: rtl/uart_rx_fifo.sv
// UART0 receive path: 8N1 deserialiser feeding a first-word fall-through FIFO.
// The irq output (UART0RX) is asserted while at least one received byte is pending.
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 10_000_000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_i,
  input  logic       rd_en,
  input  logic       clr_err,
  output logic [7:0] rd_data,
  output logic       rx_valid,
  output logic       rx_full,
  output logic       frame_err,
  output logic       overrun_err,
  output logic       irq
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int PTR_W        = $clog2(FIFO_DEPTH + 1);
  localparam int CW           = (CNT_W < 1) ? 1 : CNT_W;
  localparam int IDX_W        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t        state, state_next;
  logic [CW-1:0] baud_cnt, cnt_next;
  logic [2:0]    bit_idx, bit_next;
  logic [7:0]    shift, shift_next;
  logic          sync1, rxs;
  logic          push, frame_set;

  // The synchroniser resets to the idle level so that reset release is not mistaken for a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments keep this a true two-stage shift; blocking would collapse it to one flop.
      sync1 <= rx_i;
      rxs   <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
    end else begin
      state    <= state_next;
      baud_cnt <= cnt_next;
      bit_idx  <= bit_next;
      shift    <= shift_next;
    end
  end

  always_comb begin
    // NOTE: every output of this block is given a default first, so no path can infer a latch.
    state_next = state;
    cnt_next   = baud_cnt;
    bit_next   = bit_idx;
    shift_next = shift;
    push       = 1'b0;
    frame_set  = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rxs) begin
          state_next = START;
          cnt_next   = '0;
        end
      end
      START: begin
        if (baud_cnt == HALF_LAST) begin
          cnt_next   = '0;
          bit_next   = '0;
          state_next = rxs ? IDLE : DATA;
        end else begin
          cnt_next = baud_cnt + CW'(1);
        end
      end
      DATA: begin
        if (baud_cnt == BIT_LAST) begin
          shift_next[bit_idx] = rxs;
          cnt_next            = '0;
          if (bit_idx == 3'd7) state_next = STOP;
          else                 bit_next   = bit_idx + 3'd1;
        end else begin
          cnt_next = baud_cnt + CW'(1);
        end
      end
      STOP: begin
        if (baud_cnt == BIT_LAST) begin
          cnt_next = '0;
          if (rxs) begin
            push       = 1'b1;
            state_next = IDLE;
          end else begin
            frame_set  = 1'b1;
            state_next = WAIT_IDLE;
          end
        end else begin
          cnt_next = baud_cnt + CW'(1);
        end
      end
      WAIT_IDLE: begin
        // A held-low line (break) must return high before a new start bit is looked for.
        if (rxs) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  logic [7:0]       mem [FIFO_DEPTH];
  logic [IDX_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W-1:0] count;
  logic             full, empty, pop, wr, overrun_set;

  function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] p);
    return (p == IDX_W'(FIFO_DEPTH - 1)) ? '0 : p + IDX_W'(1);
  endfunction

  assign full        = (count == PTR_W'(FIFO_DEPTH));
  assign empty       = (count == '0);
  assign pop         = rd_en && !empty;
  assign wr          = push && (!full || pop);
  assign overrun_set = push && full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr)  wr_ptr <= ptr_inc(wr_ptr);
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      unique case ({wr, pop})
        2'b10:   count <= count + PTR_W'(1);
        2'b01:   count <= count - PTR_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; rd_data is masked while empty, so stale entries are never seen.
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= shift;
  end

  // A set in the same cycle as clr_err takes priority, so no error event is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      if (frame_set)    frame_err <= 1'b1;
      else if (clr_err) frame_err <= 1'b0;
      if (overrun_set)  overrun_err <= 1'b1;
      else if (clr_err) overrun_err <= 1'b0;
    end
  end

  assign rd_data  = empty ? 8'h00 : mem[rd_ptr];
  assign rx_valid = !empty;
  assign rx_full  = full;
  assign irq      = !empty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at 10 clocks per bit with a 4-entry FIFO.
// Inputs change 1 time unit after a rising edge; outputs are sampled on the falling edge.
module tb_uart_rx_fifo;

  localparam int CPB = 10;

  logic       clk = 1'b0;
  logic       rst_n, rx_i, rd_en, clr_err;
  logic [7:0] rd_data;
  logic       rx_valid, rx_full, frame_err, overrun_err, irq;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .CLK_FREQ  (10_000_000),
    .BAUD      (1_000_000),
    .FIFO_DEPTH(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_i       (rx_i),
    .rd_en      (rd_en),
    .clr_err    (clr_err),
    .rd_data    (rd_data),
    .rx_valid   (rx_valid),
    .rx_full    (rx_full),
    .frame_err  (frame_err),
    .overrun_err(overrun_err),
    .irq        (irq)
  );

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx_i = b;
    idle(CPB);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop_bit);
  endtask

  task automatic pop_pulse();
    rd_en = 1'b1;
    idle(1);
    rd_en = 1'b0;
  endtask

  task automatic clr_pulse();
    clr_err = 1'b1;
    idle(1);
    clr_err = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rx_i = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
    idle(3);
    @(negedge clk);
    n_cmp++;
    if ({rd_data, rx_valid, rx_full, frame_err, overrun_err, irq} !== 13'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h want 0000", {rd_data, rx_valid, rx_full, frame_err, overrun_err, irq});
    end
    idle(1);
    rst_n = 1'b1;
    idle(10);
    @(negedge clk);
    n_cmp++;
    if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL idle_after_reset rx_valid: got %b want 0", rx_valid); end
    idle(1);
  endtask

  task automatic test_single();
    send_frame(8'hA5, 1'b1);
    @(negedge clk);
    n_cmp++;
    if ({rx_valid, irq} !== 2'b11) begin n_bad++; $display("FAIL single valid/irq: got %b want 11", {rx_valid, irq}); end
    n_cmp++;
    if (rd_data !== 8'hA5) begin n_bad++; $display("FAIL single rd_data: got %h want a5", rd_data); end
    idle(1);
    pop_pulse();
    @(negedge clk);
    n_cmp++;
    if ({rx_valid, irq, rd_data} !== 10'h0) begin n_bad++; $display("FAIL single after_pop: got %h want 000", {rx_valid, irq, rd_data}); end
    // Pop while empty must leave the pointers alone.
    idle(1);
    pop_pulse();
    send_frame(8'h6B, 1'b1);
    @(negedge clk);
    n_cmp++;
    if ({rx_valid, rd_data} !== {1'b1, 8'h6B}) begin n_bad++; $display("FAIL empty_pop then rx: got %h want 16b", {rx_valid, rd_data}); end
    idle(1);
    pop_pulse();
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
    for (int i = 0; i < 4; i++) send_frame(exp[i], 1'b1);
    @(negedge clk);
    n_cmp++;
    if (rx_full !== 1'b1) begin n_bad++; $display("FAIL b2b rx_full: got %b want 1", rx_full); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (rd_data !== exp[i]) begin n_bad++; $display("FAIL b2b pop%0d: got %h want %h", i, rd_data, exp[i]); end
      idle(1);
      pop_pulse();
    end
    @(negedge clk);
    n_cmp++;
    if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL b2b drained rx_valid: got %b want 0", rx_valid); end
    idle(1);
  endtask

  task automatic test_overrun();
    logic [7:0] exp [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
    for (int i = 0; i < 4; i++) send_frame(exp[i], 1'b1);
    send_frame(8'h55, 1'b1);
    @(negedge clk);
    n_cmp++;
    if ({overrun_err, rx_full} !== 2'b11) begin n_bad++; $display("FAIL overrun flag/full: got %b want 11", {overrun_err, rx_full}); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (rd_data !== exp[i]) begin n_bad++; $display("FAIL overrun pop%0d: got %h want %h", i, rd_data, exp[i]); end
      idle(1);
      pop_pulse();
    end
    @(negedge clk);
    n_cmp++;
    if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL overrun dropped byte visible: rx_valid %b want 0", rx_valid); end
    idle(1);
    clr_pulse();
    @(negedge clk);
    n_cmp++;
    if (overrun_err !== 1'b0) begin n_bad++; $display("FAIL overrun clr: got %b want 0", overrun_err); end
    idle(1);
  endtask

  task automatic test_push_pop_full();
    logic [7:0] exp [4] = '{8'h02, 8'h03, 8'h04, 8'h55};
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1);
    // The stop bit is sampled at the 8th rising edge of the stop bit; pop on exactly that edge.
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(exp[3][i]);
    rx_i = 1'b1;
    idle(7);
    rd_en = 1'b1;
    idle(1);
    rd_en = 1'b0;
    idle(2);
    @(negedge clk);
    n_cmp++;
    if ({overrun_err, rx_full} !== 2'b01) begin n_bad++; $display("FAIL pushpop overrun/full: got %b want 01", {overrun_err, rx_full}); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (rd_data !== exp[i]) begin n_bad++; $display("FAIL pushpop pop%0d: got %h want %h", i, rd_data, exp[i]); end
      idle(1);
      pop_pulse();
    end
    @(negedge clk);
    n_cmp++;
    if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL pushpop drained rx_valid: got %b want 0", rx_valid); end
    idle(1);
  endtask

  task automatic test_frame_err();
    send_frame(8'h3C, 1'b0);
    idle(50);
    rx_i = 1'b1;
    idle(20);
    @(negedge clk);
    n_cmp++;
    if ({frame_err, rx_valid} !== 2'b10) begin n_bad++; $display("FAIL frame_err set/no push: got %b want 10", {frame_err, rx_valid}); end
    idle(1);
    send_frame(8'h7E, 1'b1);
    @(negedge clk);
    n_cmp++;
    if ({rx_valid, rd_data, frame_err} !== {1'b1, 8'h7E, 1'b1}) begin
      n_bad++; $display("FAIL frame_err next byte: got %h want 2fd", {rx_valid, rd_data, frame_err});
    end
    idle(1);
    pop_pulse();
    clr_pulse();
    @(negedge clk);
    n_cmp++;
    if ({frame_err, rx_valid} !== 2'b00) begin n_bad++; $display("FAIL frame_err clr: got %b want 00", {frame_err, rx_valid}); end
    idle(1);
  endtask

  task automatic test_glitch();
    rx_i = 1'b0;
    idle(3);
    rx_i = 1'b1;
    idle(30);
    @(negedge clk);
    n_cmp++;
    if ({rx_valid, frame_err} !== 2'b00) begin n_bad++; $display("FAIL glitch push/err: got %b want 00", {rx_valid, frame_err}); end
    idle(1);
    send_frame(8'h81, 1'b1);
    @(negedge clk);
    n_cmp++;
    if ({rx_valid, rd_data} !== {1'b1, 8'h81}) begin n_bad++; $display("FAIL glitch then rx: got %h want 181", {rx_valid, rd_data}); end
    idle(1);
    pop_pulse();
  endtask

  task automatic test_reset_mid_frame();
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    @(negedge clk);
    n_cmp++;
    if ({rx_valid, rd_data} !== {1'b1, 8'h11}) begin n_bad++; $display("FAIL midrst preload: got %h want 111", {rx_valid, rd_data}); end
    idle(1);
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    rst_n = 1'b0;
    #2;
    n_cmp++;
    if ({rd_data, rx_valid, rx_full, frame_err, overrun_err, irq} !== 13'h0) begin
      n_bad++; $display("FAIL midrst async outputs: got %h want 0000", {rd_data, rx_valid, rx_full, frame_err, overrun_err, irq});
    end
    rx_i = 1'b1;
    idle(3);
    rst_n = 1'b1;
    idle(20);
    send_frame(8'hC3, 1'b1);
    @(negedge clk);
    n_cmp++;
    if ({rx_valid, rd_data} !== {1'b1, 8'hC3}) begin n_bad++; $display("FAIL midrst next frame: got %h want 1c3", {rx_valid, rd_data}); end
    idle(1);
    pop_pulse();
    @(negedge clk);
    n_cmp++;
    if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL midrst stale bytes: rx_valid %b want 0", rx_valid); end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_push_pop_full();
    test_frame_err();
    test_glitch();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- UART0 receive path: deserialises 8N1 frames from the external RX pin into bytes.
- Buffers received bytes in a small FIFO and raises the UART0RX interrupt (trap code 16) while data is pending.
- Counterpart to the existing UART0 transmitter.
- Sits behind the UART0 register block at 0xFFFF_FF8F; the register block drives the pop and error-clear strobes.

Parameters:
- CLK_FREQ, 10_000_000, core clock in Hz.
- BAUD, 9600, line rate in bit/s.
- FIFO_DEPTH, 8, receive FIFO entries; must be >= 1.
- Derived, not overridable: CLKS_PER_BIT = CLK_FREQ/BAUD (integer division, 1041 at defaults).
- Derived, not overridable: HALF_BIT = CLKS_PER_BIT/2.
- Derived, not overridable: CNT_W = $clog2(CLKS_PER_BIT).
- Derived, not overridable: PTR_W = $clog2(FIFO_DEPTH+1).

Ports:
- clk  input  1  core clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rx_i  input  1  asynchronous serial line; idle high.
- rd_en  input  1  pop strobe; honoured only when rx_valid=1.
- clr_err  input  1  one-cycle strobe; clears frame_err and overrun_err.
- rd_data  output  8  FIFO head (first-word fall-through); 0 when empty.
- rx_valid  output  1  FIFO non-empty.
- rx_full  output  1  FIFO holds FIFO_DEPTH entries.
- frame_err  output  1  sticky: a stop bit was sampled low.
- overrun_err  output  1  sticky: a good byte arrived while the FIFO was full.
- irq  output  1  UART0RX interrupt; level, equals rx_valid.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - FSM to IDLE; bit and baud counters to 0.
  - FIFO pointers and count to 0.
  - Synchroniser flops to 1.
  - All outputs 0 (rd_data=8'h00, rx_valid=rx_full=frame_err=overrun_err=irq=0).
  - Reset mid-frame discards the partial byte and all buffered bytes.
- Input sync: rx_i passes through 2 flops; the FSM uses only the synchronised value rxs.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE: rxs=0 -> START, baud_cnt=0.
- START:
  - At baud_cnt==HALF_BIT-1, if rxs=0 -> DATA, baud_cnt=0, bit_idx=0.
  - If rxs=1 at that point -> IDLE (glitch rejected, nothing pushed).
- DATA:
  - At baud_cnt==CLKS_PER_BIT-1, sample rxs into shift[bit_idx]; LSB first; baud_cnt=0.
  - After bit_idx==7 is sampled -> STOP.
- STOP, at baud_cnt==CLKS_PER_BIT-1:
  - rxs=1: push the byte, -> IDLE.
  - rxs=0: frame_err<=1, byte discarded, -> WAIT_IDLE.
- WAIT_IDLE: stay until rxs=1, then -> IDLE. Prevents a break condition from retriggering START.
- Push when the FIFO is full and no pop in the same cycle: byte dropped, overrun_err<=1, FIFO contents unchanged.
- Push and pop in the same cycle:
  - Full: both happen; count unchanged; no overrun.
  - Empty: pop ignored, push happens; count becomes 1.
- rd_en with rx_valid=0: no effect; pointers and count unchanged.
- Pointers wrap modulo FIFO_DEPTH; the count register distinguishes full from empty.
- Latency: a pushed byte is visible on rd_data/rx_valid/irq on the cycle after the stop-sample edge.
- Pop takes effect at the clock edge; the next head appears on rd_data in the following cycle.
- clr_err and an error set in the same cycle: set wins (flag stays 1).
- Frame timing: total frame ~10*CLKS_PER_BIT cycles plus 2 synchroniser cycles; back-to-back frames with no idle gap are accepted.

Test Plan:
All scenarios run with CLK_FREQ=10_000_000, BAUD=1_000_000 (CLKS_PER_BIT=10), FIFO_DEPTH=4.
- Single frame 0xA5, 8N1 -> rx_valid=irq=1 and rd_data=8'hA5 within 104 cycles of the start edge; rd_en pulse -> rx_valid=0, rd_data=0.
- Back-to-back frames 0x01,0x02,0x03,0x04, no idle gap -> rx_full=1, FIFO pops in order 01,02,03,04.
- Fifth frame 0x55 while full, no pop -> overrun_err=1, count stays 4, byte 0x55 never read.
- Same as above but rd_en asserted on the push cycle -> no overrun; read order 02,03,04,55.
- Frame 0x3C with stop bit low, line held low 50 cycles, then 0x7E -> frame_err=1; no push for 0x3C; 0x7E received correctly. clr_err -> frame_err=0.
- 3-cycle low glitch on rx_i -> no push, FSM back to IDLE.
- rst_n pulsed low mid-DATA with 2 bytes buffered -> all outputs 0 immediately; next clean frame received correctly.
